// File: rtl/tdm_demux_1x2.sv
// rtl/tdm_demux_1x2.sv - two-slot time-division demultiplexer with frame lock
//
// Splits an interleaved slot-A/slot-B sample stream back into two channels.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in, valid, sync multiplexed sample, beat qualifier, slot-A marker
//   a, b            last captured slot-A / slot-B samples (held)
//   a_vld, b_vld    one-cycle capture pulses
//   pair_vld        a/b belong to one frame (coincident with b_vld)
//   err             one-cycle framing error pulse
//   locked          frame lock held (EXP_A or EXP_B)
//   frames          completed-frame count, wraps silently

module tdm_demux_1x2 #(
    parameter int WIDTH = 1,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             valid,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             a_vld,
    output logic             b_vld,
    output logic             pair_vld,
    output logic             err,
    output logic             locked,
    output logic [CNTW-1:0]  frames
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        EXP_B = 2'd1,
        EXP_A = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt;
    logic             a_vld_nxt, b_vld_nxt, pair_vld_nxt, err_nxt;
    logic [CNTW-1:0]  frames_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            a        <= '0;
            b        <= '0;
            a_vld    <= 1'b0;
            b_vld    <= 1'b0;
            pair_vld <= 1'b0;
            err      <= 1'b0;
            frames   <= '0;
        end else begin
            state    <= state_nxt;
            a        <= a_nxt;
            b        <= b_nxt;
            a_vld    <= a_vld_nxt;
            b_vld    <= b_vld_nxt;
            pair_vld <= pair_vld_nxt;
            err      <= err_nxt;
            frames   <= frames_nxt;
        end
    end

    // Lock is a pure decode of the state flop, so it is glitch-free and
    // changes on the same edge as the beat that moved the state.
    assign locked = (state != HUNT);

    always_comb begin
        state_nxt    = state;
        a_nxt        = a;
        b_nxt        = b;
        a_vld_nxt    = 1'b0;
        b_vld_nxt    = 1'b0;
        pair_vld_nxt = 1'b0;
        err_nxt      = 1'b0;
        frames_nxt   = frames;
        if (valid) begin
            case (state)
                HUNT: begin
                    // Non-sync beats are discarded quietly until the first slot A.
                    if (sync) begin
                        a_nxt     = in;
                        a_vld_nxt = 1'b1;
                        state_nxt = EXP_B;
                    end
                end
                EXP_B: begin
                    if (sync) begin
                        // B slot went missing: restart the frame on this A.
                        err_nxt   = 1'b1;
                        a_nxt     = in;
                        a_vld_nxt = 1'b1;
                    end else begin
                        b_nxt        = in;
                        b_vld_nxt    = 1'b1;
                        pair_vld_nxt = 1'b1;
                        frames_nxt   = frames + CNTW'(1);
                        state_nxt    = EXP_A;
                    end
                end
                EXP_A: begin
                    if (sync) begin
                        a_nxt     = in;
                        a_vld_nxt = 1'b1;
                        state_nxt = EXP_B;
                    end else begin
                        // A third slot where A belongs: alignment is gone.
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

endmodule
